// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory bus between the instruction-fetch port and the
// data port. A watchdog aborts hung bus transactions and raises a sticky error flag.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter bit DATA_PRIO = 1'b1,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              rst,
    // instruction-fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    // data (MEM-stage) port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_funct3,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_stall,
    // shared memory bus
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int                CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEAD_BEEF);
    localparam logic [2:0]        FETCH_F3   = 3'b010;

    logic [1:0]       state;
    logic             grant_d;   // 1: current transaction belongs to the data port
    logic             last_d;    // 1: previous completed transaction was a data access
    logic [CNT_W-1:0] wd_cnt;
    logic             err_q;

    logic pick_d;
    logic issue;
    logic wd_fire;
    logic done_ok;
    logic done_abort;
    logic capture;
    logic in_resp;

    // NOTE: every variable assigned in a combinational block gets a default first,
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        pick_d = d_req;
        if (d_req && if_req) begin
            pick_d = DATA_PRIO ? 1'b1 : ~last_d;
        end
    end

    assign issue      = (state == IDLE) && (if_req || d_req);
    assign wd_fire    = (TIMEOUT != 0) && (wd_cnt == CNT_LAST);
    assign done_ok    = (state == BUSY) && mem_ready;
    assign done_abort = (state == BUSY) && !mem_ready && wd_fire;
    assign capture    = done_ok || done_abort;
    assign in_resp    = (state == RESP);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            grant_d <= 1'b0;
            last_d  <= 1'b1;
            wd_cnt  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        grant_d <= pick_d;
                        wd_cnt  <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (done_ok) begin
                        state <= RESP;
                    end else if (done_abort) begin
                        err_q <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP: begin
                    last_d <= grant_d;
                    wd_cnt <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: these are a handful of flops rather than a memory array, so they are
    // reset to give the all-zero output state out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_funct3 <= '0;
        end else if (issue) begin
            if (pick_d) begin
                mem_we     <= d_we;
                mem_addr   <= d_addr;
                mem_wdata  <= d_wdata;
                mem_funct3 <= d_funct3;
            end else begin
                mem_we     <= 1'b0;
                mem_addr   <= if_addr;
                mem_wdata  <= '0;
                mem_funct3 <= FETCH_F3;
            end
        end
    end

    // Read data lands in the granted port's register only; the other port keeps its value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else if (capture) begin
            if (grant_d) begin
                d_rdata <= done_ok ? mem_rdata : ABORT_DATA;
            end else begin
                if_rdata <= done_ok ? mem_rdata : ABORT_DATA;
            end
        end
    end

    // A port that withdrew its request while BUSY gets no acknowledge.
    assign if_ack   = in_resp && !grant_d && if_req;
    assign d_ack    = in_resp && grant_d && d_req;
    assign if_stall = if_req && !if_ack;
    assign d_stall  = d_req && !d_ack;
    assign mem_req  = (state == BUSY);
    assign err      = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: instance 0 uses data priority with an 8-cycle watchdog,
// instance 1 uses round-robin ties with the watchdog disabled.
module tb_mem_port_arbiter;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          TO0   = 8;
    localparam int          TO1   = 0;
    localparam logic [31:0] ABORT = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          if_req[2],  if_ack[2], if_stall[2];
    logic [AW-1:0] if_addr[2];
    logic [DW-1:0] if_rdata[2];
    logic          d_req[2], d_we[2], d_ack[2], d_stall[2];
    logic [AW-1:0] d_addr[2];
    logic [DW-1:0] d_wdata[2], d_rdata[2];
    logic [2:0]    d_funct3[2];
    logic          mem_req[2], mem_we[2], mem_ready[2], err[2];
    logic [AW-1:0] mem_addr[2];
    logic [DW-1:0] mem_wdata[2], mem_rdata[2];
    logic [2:0]    mem_funct3[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W(AW), .DATA_W(DW), .DATA_PRIO(g == 0), .TIMEOUT(g == 0 ? TO0 : TO1)
        ) dut (
            .clk(clk), .rst(rst),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]),
            .if_ack(if_ack[g]), .if_stall(if_stall[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_funct3(d_funct3[g]), .d_rdata(d_rdata[g]), .d_ack(d_ack[g]), .d_stall(d_stall[g]),
            .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_funct3(mem_funct3[g]),
            .mem_ready(mem_ready[g]), .mem_rdata(mem_rdata[g]), .err(err[g])
        );
    end

    // Reference model: per-instance configuration and architectural state.
    bit          prio[2] = '{1'b1, 1'b0};
    int          tmo[2]  = '{TO0, TO1};
    bit          m_last_d[2];
    bit          m_err[2];
    logic [31:0] m_ird[2], m_drd[2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_last_d[k] = 1'b1;
            m_err[k]    = 1'b0;
            m_ird[k]    = '0;
            m_drd[k]    = '0;
        end
    endtask

    task automatic set_i(input int k, input logic [31:0] addr);
        if_req[k]  = 1'b1;
        if_addr[k] = addr;
    endtask

    task automatic set_d(input int k, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3);
        d_req[k]    = 1'b1;
        d_we[k]     = we;
        d_addr[k]   = addr;
        d_wdata[k]  = wdata;
        d_funct3[k] = f3;
    endtask

    // Runs one bus transaction. Call at a negedge while the DUT is IDLE with requests set.
    // lat = BUSY cycle index (0-based) on which memory answers; -1 means never.
    task automatic serve(input int k, input int lat, input logic [31:0] rd_val, input bit withdraw,
                         input string tag, output logic obs_we, output int resp_cyc);
        bit          win_d, hit, abort, exp_iack, exp_dack;
        logic        exp_we;
        logic [31:0] exp_addr, exp_data;
        logic [2:0]  exp_f3;
        if (if_req[k] && d_req[k]) win_d = prio[k] ? 1'b1 : !m_last_d[k];
        else                       win_d = d_req[k];
        exp_we   = win_d ? d_we[k] : 1'b0;
        exp_addr = win_d ? d_addr[k] : if_addr[k];
        exp_f3   = win_d ? d_funct3[k] : 3'b010;
        @(negedge clk);
        obs_we = mem_we[k];
        check({tag, " mem_req"}, mem_req[k], 1'b1);
        check({tag, " mem_we"}, mem_we[k], exp_we);
        check({tag, " mem_addr"}, mem_addr[k], exp_addr);
        check({tag, " mem_funct3"}, mem_funct3[k], exp_f3);
        if (win_d) check({tag, " mem_wdata"}, mem_wdata[k], d_wdata[k]);
        if (withdraw) begin
            if (win_d) d_req[k] = 1'b0;
            else       if_req[k] = 1'b0;
        end
        hit   = 1'b0;
        abort = 1'b0;
        for (int j = 0; j < 100; j++) begin
            hit   = (j == lat);
            abort = !hit && (tmo[k] != 0) && (j == tmo[k] - 1);
            mem_ready[k] = hit;
            mem_rdata[k] = hit ? rd_val : $urandom();
            if (hit || abort) break;
            @(negedge clk);
            check({tag, " busy mem_req"}, mem_req[k], 1'b1);
            check({tag, " busy stalls"}, {if_stall[k], d_stall[k]}, {if_req[k], d_req[k]});
        end
        check({tag, " bus completion bound"}, hit || abort, 1'b1);
        @(negedge clk);
        resp_cyc     = cyc;
        mem_ready[k] = 1'b0;
        exp_data     = hit ? rd_val : ABORT;
        if (!hit) m_err[k] = 1'b1;
        if (win_d) m_drd[k] = exp_data;
        else       m_ird[k] = exp_data;
        exp_iack = !win_d && !withdraw;
        exp_dack = win_d && !withdraw;
        check({tag, " resp acks"}, {if_ack[k], d_ack[k]}, {exp_iack, exp_dack});
        check({tag, " resp mem_req"}, mem_req[k], 1'b0);
        check({tag, " if_rdata"}, if_rdata[k], m_ird[k]);
        check({tag, " d_rdata"}, d_rdata[k], m_drd[k]);
        check({tag, " err"}, err[k], m_err[k]);
        check({tag, " resp stalls"}, {if_stall[k], d_stall[k]},
              {if_req[k] && !exp_iack, d_req[k] && !exp_dack});
        m_last_d[k] = win_d;
        if (win_d) d_req[k] = 1'b0;
        else       if_req[k] = 1'b0;
        @(negedge clk);
        check({tag, " idle acks"}, {if_ack[k], d_ack[k], mem_req[k]}, 3'b000);
    endtask

    initial begin
        #500000;
        $display("FAIL global time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic        owe;
        int          rc, t0, lat;
        logic [31:0] keep_i, keep_d;
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 0; if_addr[k] = '0; d_req[k] = 0; d_we[k] = 0; d_addr[k] = '0;
            d_wdata[k] = '0; d_funct3[k] = '0; mem_ready[k] = 0; mem_rdata[k] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset ctrl", {mem_req[k], mem_we[k], if_ack[k], d_ack[k], err[k],
                                 if_stall[k], d_stall[k]}, 7'b0);
            check("reset bus", {mem_addr[k], mem_wdata[k]}, 64'h0);
            check("reset funct3", mem_funct3[k], 3'b000);
            check("reset rdata", {if_rdata[k], d_rdata[k]}, 64'h0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Fetch only, memory answers two cycles after mem_req rises.
        set_i(0, 32'h100);
        t0 = cyc;
        serve(0, 2, 32'h0050_0093, 1'b0, "t1 fetch", owe, rc);
        check("t1 req to ack cycles", rc - t0, 4);

        // Tie with data priority: the store goes first, then the held fetch.
        set_i(0, 32'h104);
        set_d(0, 1'b1, 32'h2000, 32'hCAFE, 3'b010);
        serve(0, 1, 32'h0, 1'b0, "t2 store", owe, rc);
        check("t2 first grant is store", owe, 1'b1);
        serve(0, 3, 32'h1111_2222, 1'b0, "t2 fetch", owe, rc);
        check("t2 second grant is fetch", owe, 1'b0);

        // Ready on the watchdog cycle itself: normal completion, no error.
        set_d(0, 1'b0, 32'h3000, 32'h0, 3'b100);
        serve(0, TO0 - 1, 32'h1234_5678, 1'b0, "t5 ready at limit", owe, rc);

        // Memory never answers: abort after TO0 BUSY cycles.
        set_i(0, 32'h200);
        t0 = cyc;
        serve(0, -1, 32'h0, 1'b0, "t4 abort", owe, rc);
        check("t4 req to ack cycles", rc - t0, TO0 + 1);
        set_d(0, 1'b1, 32'h2004, 32'h55AA, 3'b001);
        serve(0, 0, 32'h0, 1'b0, "t4 err sticky", owe, rc);

        // Withdrawn fetch completes on the bus without an acknowledge.
        set_i(0, 32'h300);
        serve(0, 3, m_ird[0], 1'b1, "withdraw", owe, rc);

        // mem_ready while IDLE must be ignored.
        keep_i = m_ird[0];
        keep_d = m_drd[0];
        mem_ready[0] = 1'b1;
        mem_rdata[0] = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_ready[0] = 1'b0;
        check("idle ready no req", mem_req[0], 1'b0);
        check("idle ready no ack", {if_ack[0], d_ack[0]}, 2'b00);
        check("idle ready rdata", {if_rdata[0], d_rdata[0]}, {keep_i, keep_d});

        // Asynchronous reset in the middle of BUSY, then the held request re-issues.
        set_i(0, 32'h400);
        @(negedge clk);
        check("t6 busy", mem_req[0], 1'b1);
        #2 rst = 1'b0;
        #1;
        check("t6 reset drops bus", {mem_req[0], if_ack[0], d_ack[0]}, 3'b000);
        check("t6 reset clears err", err[0], 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        serve(0, 1, 32'hABCD_0001, 1'b0, "t6 reissue", owe, rc);

        // Round-robin ties: after a fetch, continuous requests alternate D,I,D,I.
        set_i(1, 32'h500);
        serve(1, 0, 32'h0BAD_F00D, 1'b0, "t3 warmup", owe, rc);
        for (int n = 0; n < 4; n++) begin
            if (!if_req[1]) set_i(1, 32'h600 + 32'(n * 4));
            if (!d_req[1])  set_d(1, 1'b1, 32'h7000 + 32'(n * 4), $urandom(), 3'b010);
            serve(1, n, $urandom(), 1'b0, "t3 rr", owe, rc);
            check("t3 alternation", owe, (n % 2) == 0);
        end
        if_req[1] = 1'b0;
        d_req[1]  = 1'b0;
        @(negedge clk);

        // Randomized traffic on both configurations; losers keep their request held.
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 25; n++) begin
                if (!if_req[k] && ($urandom_range(0, 1) == 1))
                    set_i(k, $urandom() & 32'hFFFF_FFFC);
                if (!d_req[k] && (($urandom_range(0, 1) == 1) || !if_req[k]))
                    set_d(k, 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                          3'($urandom_range(0, 7)));
                lat = (k == 0 && $urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 9);
                serve(k, lat, $urandom(), 1'b0, "rand", owe, rc);
            end
            if_req[k] = 1'b0;
            d_req[k]  = 1'b0;
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
